// File: rtl/karatsuba_split_sched_26bit.sv
// One Karatsuba level of carry-less (GF(2)) multiplication. The three half-size
// products go one at a time to a shared sub-multiplier, then are folded into the result.
module karatsuba_split_sched_26bit #(
   parameter  int N = 26,
   localparam int M = N / 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   output logic             sub_req_valid,
   input  logic             sub_req_ready,
   output logic [M-1:0]     sub_a,
   output logic [M-1:0]     sub_b,
   input  logic             sub_rsp_valid,
   input  logic [2*M-2:0]   sub_rsp_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-2:0]   out_p,
   output logic             err
);

   // state   | meaning
   // IDLE    | waiting for an operand pair, in_ready high
   // ISSUE   | request for product idx presented on sub_a/sub_b
   // WAIT    | request accepted, waiting for its response pulse
   // COMBINE | fold P0/P1/P2 into out_p
   // DONE    | out_p valid until the consumer takes it
   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_COMBINE,
      S_DONE
   } state_t;

   localparam int PW = 2 * M - 1;
   localparam int OW = 2 * N - 1;

   state_t          state;
   logic [1:0]      idx;
   logic [M-1:0]    a_l, a_h, b_l, b_h;
   logic [PW-1:0]   p0, p1, p2;

   logic [1:0]      idx_nxt;
   logic [M-1:0]    nxt_sub_a, nxt_sub_b;
   logic [PW-1:0]   mc;
   logic [OW-1:0]   prod;

   // Only indices 1 (high) and 2 (mid) are ever issued from WAIT.
   always_comb begin
      idx_nxt   = idx + 2'd1;
      nxt_sub_a = a_l ^ a_h;
      nxt_sub_b = b_l ^ b_h;
      if (idx_nxt == 2'd1) begin
         nxt_sub_a = a_h;
         nxt_sub_b = b_h;
      end
   end

   // The mid product contains P0 and P1 as well; removing them leaves the cross term.
   always_comb begin
      mc   = p2 ^ p0 ^ p1;
      prod = OW'(p0) ^ (OW'(mc) << M) ^ (OW'(p1) << N);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         idx           <= 2'd0;
         in_ready      <= 1'b1;
         sub_req_valid <= 1'b0;
         sub_a         <= '0;
         sub_b         <= '0;
         out_valid     <= 1'b0;
         out_p         <= '0;
         err           <= 1'b0;
         a_l           <= '0;
         a_h           <= '0;
         b_l           <= '0;
         b_h           <= '0;
         p0            <= '0;
         p1            <= '0;
         p2            <= '0;
      end else begin
         err <= sub_rsp_valid && (state != S_WAIT);
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  a_l           <= in_a[M-1:0];
                  a_h           <= in_a[N-1:M];
                  b_l           <= in_b[M-1:0];
                  b_h           <= in_b[N-1:M];
                  sub_a         <= in_a[M-1:0];
                  sub_b         <= in_b[M-1:0];
                  idx           <= 2'd0;
                  sub_req_valid <= 1'b1;
                  in_ready      <= 1'b0;
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (sub_req_ready) begin
                  sub_req_valid <= 1'b0;
                  state         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (sub_rsp_valid) begin
                  case (idx)
                     2'd0:    p0 <= sub_rsp_data;
                     2'd1:    p1 <= sub_rsp_data;
                     default: p2 <= sub_rsp_data;
                  endcase
                  if (idx == 2'd2) begin
                     state <= S_COMBINE;
                  end else begin
                     idx           <= idx_nxt;
                     sub_a         <= nxt_sub_a;
                     sub_b         <= nxt_sub_b;
                     sub_req_valid <= 1'b1;
                     state         <= S_ISSUE;
                  end
               end
            end
            S_COMBINE: begin
               out_p     <= prod;
               out_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               sub_req_valid <= 1'b0;
               out_valid     <= 1'b0;
               in_ready      <= 1'b1;
               state         <= S_IDLE;
            end
         endcase
      end
   end

endmodule
